// File: rtl/ctrl_burst_cas_pkg.sv
// Shared types and DDR timing constants for the column-command stage.
// Request type encodings, CAS FSM states and default timing values.
// Imported by the interface and the top module.
package ctrl_burst_cas_pkg;

  typedef enum logic [2:0] {
    RD_R = 3'b001,
    WR_R = 3'b010
  } req_type_t;

  typedef enum logic [1:0] {
    CAS_IDLE,
    CAS_WAIT_RCD,
    CAS_WAIT_GAP,
    CAS_DATA
  } cas_fsm_type;

  localparam int DDR_COL_W = 10;
  localparam int DDR_TRCD  = 16;
  localparam int DDR_TCCD  = 4;
  localparam int DDR_TWTR  = 4;
  localparam int DDR_CL    = 16;
  localparam int DDR_CWL   = 12;
  localparam int DDR_BL    = 8;

endpackage

// File: rtl/ctrl_burst_cas_if.sv
// Request/command bundle between the ACT controller, this stage and the PHY side.
// master drives the request pulses; slave (ctrl_burst_cas) drives CAS and data timing.
// No flow control: requests are single-cycle pulses, outputs are registered pulses/levels.
interface ctrl_burst_cas_if
  import ctrl_burst_cas_pkg::*;
#(
  parameter int COL_W = DDR_COL_W
);
  logic             act_rdy;
  logic             no_act_rdy;
  logic [2:0]       act_rw;
  logic [COL_W-1:0] col_addr;
  logic             cas_rdy;
  logic [2:0]       cas_req;
  logic [COL_W-1:0] cas_col;
  logic             data_start;
  logic             data_busy;
  logic             cas_idle;
  logic             req_err;

  modport master (
    output act_rdy, no_act_rdy, act_rw, col_addr,
    input  cas_rdy, cas_req, cas_col, data_start, data_busy, cas_idle, req_err
  );

  modport slave (
    input  act_rdy, no_act_rdy, act_rw, col_addr,
    output cas_rdy, cas_req, cas_col, data_start, data_busy, cas_idle, req_err
  );
endinterface

// File: rtl/ctrl_burst_cas.sv
// Column-command stage: waits tRCD/tCCD/tWTR, pulses cas_rdy, then times the data phase.
// Latency: row hit 1 cycle accept->cas_rdy; after ACT tRCD cycles; data at +CL/+CWL.
// Backpressure: none; requests are accepted only in CAS_IDLE, others are dropped.
module ctrl_burst_cas
  import ctrl_burst_cas_pkg::*;
#(
  parameter int COL_W = DDR_COL_W,
  parameter int tRCD  = DDR_TRCD,
  parameter int tCCD  = DDR_TCCD,
  parameter int tWTR  = DDR_TWTR,
  parameter int CL    = DDR_CL,
  parameter int CWL   = DDR_CWL,
  parameter int BL    = DDR_BL
) (
  input  logic             CK_t,
  input  logic             reset,
  ctrl_burst_cas_if.slave  bus
);

  localparam logic [7:0] RCD_LAST  = 8'(tRCD - 1);
  localparam logic [7:0] CCD_MIN   = 8'(tCCD - 1);
  localparam logic [7:0] WTR_MIN   = 8'(CWL + BL / 2 + tWTR - 1);
  localparam logic [7:0] CL_M1     = 8'(CL - 1);
  localparam logic [7:0] CWL_M1    = 8'(CWL - 1);
  localparam logic [7:0] HALF_BL   = 8'(BL / 2);
  localparam logic [7:0] BURST_END = 8'(BL / 2 + 1);

  cas_fsm_type state, state_nxt;
  logic [7:0]  wait_cnt;
  logic [7:0]  gap_cnt;
  logic        last_wr;
  logic        accept;
  logic        type_ok;
  logic        gap_ok;
  logic        cas_fire;
  logic [7:0]  lat_m1;
  logic [7:0]  busy_end;
  logic [7:0]  done_cnt;

  // Next-state decode plus the spacing and data-window terms the register stage needs.
  always_comb begin
    state_nxt = state;
    accept    = (state == CAS_IDLE) && (bus.act_rdy || bus.no_act_rdy);
    type_ok   = (bus.act_rw == RD_R) || (bus.act_rw == WR_R);
    // A read following a write must also clear the write data plus tWTR.
    gap_ok    = (gap_cnt >= CCD_MIN) &&
                !((bus.cas_req == RD_R) && last_wr && (gap_cnt < WTR_MIN));
    cas_fire  = (state == CAS_WAIT_GAP) && gap_ok;
    lat_m1    = (bus.cas_req == WR_R) ? CWL_M1 : CL_M1;
    busy_end  = lat_m1 + HALF_BL;
    done_cnt  = lat_m1 + BURST_END;
    case (state)
      CAS_IDLE: begin
        // act_rdy wins over no_act_rdy so tRCD is never skipped.
        if (accept && type_ok) state_nxt = bus.act_rdy ? CAS_WAIT_RCD : CAS_WAIT_GAP;
      end
      CAS_WAIT_RCD: if (wait_cnt == RCD_LAST) state_nxt = CAS_WAIT_GAP;
      CAS_WAIT_GAP: if (gap_ok) state_nxt = CAS_DATA;
      CAS_DATA:     if (wait_cnt == done_cnt) state_nxt = CAS_IDLE;
      default:      state_nxt = CAS_IDLE;
    endcase
  end

  // State, counters and all registered outputs.
  always_ff @(posedge CK_t) begin
    if (reset) begin
      state          <= CAS_IDLE;
      wait_cnt       <= 8'd0;
      gap_cnt        <= 8'hFF;
      last_wr        <= 1'b0;
      bus.cas_rdy    <= 1'b0;
      bus.cas_req    <= 3'd0;
      bus.cas_col    <= '0;
      bus.data_start <= 1'b0;
      bus.data_busy  <= 1'b0;
      bus.cas_idle   <= 1'b1;
      bus.req_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      // The accept cycle already counts toward tRCD, so that wait starts at 1.
      if (state_nxt != state)
        wait_cnt <= (state_nxt == CAS_WAIT_RCD) ? 8'd1 : 8'd0;
      else if (wait_cnt != 8'hFF)
        wait_cnt <= wait_cnt + 8'd1;

      if (cas_fire)
        gap_cnt <= 8'd0;
      else if (gap_cnt != 8'hFF)
        gap_cnt <= gap_cnt + 8'd1;

      bus.cas_rdy <= cas_fire;
      if (cas_fire) last_wr <= (bus.cas_req == WR_R);

      if (accept) begin
        bus.cas_req <= bus.act_rw;
        bus.cas_col <= bus.col_addr;
      end
      bus.req_err <= accept && !type_ok;

      bus.data_start <= (state == CAS_DATA) && (wait_cnt == lat_m1);
      bus.data_busy  <= (state == CAS_DATA) && (wait_cnt >= lat_m1) && (wait_cnt < busy_end);
      bus.cas_idle   <= (state_nxt == CAS_IDLE);
    end
  end

endmodule

// File: tb/tb_ctrl_burst_cas.sv
// Bench for ctrl_burst_cas: directed scenarios followed by randomized requests.
// Expected timing comes from a max-of-constraints model of tRCD/tCCD/tWTR and CL/CWL.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_ctrl_burst_cas;
  import ctrl_burst_cas_pkg::*;

  localparam int T_RCD = 16;
  localparam int T_CCD = 4;
  localparam int T_WTR = 4;
  localparam int L_RD  = 16;
  localparam int L_WR  = 12;
  localparam int HALF  = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  // Reference model state: cycle of the last CAS and whether it was a write.
  int   prev_cas = -1000;
  bit   last_wr_m = 1'b0;

  ctrl_burst_cas_if #(.COL_W(10)) bus ();

  ctrl_burst_cas dut (
    .CK_t  (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no finish, required finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    prev_cas  = -1000;
    last_wr_m = 1'b0;
  endtask

  // Waits pre cycles, pulses a request (path 0 hit, 1 act, 2 both), then checks it end to end.
  task automatic issue(input int pre, input int path, input logic [2:0] rw,
                       input logic [9:0] col, input string tag);
    int a, exp_cas, lat, t_cas, t_ds, t_busy0, n_busy, n_cas, n_err, t_idle;
    logic idle_at_a;
    logic [9:0] col_seen;
    logic [2:0] req_seen;
    bit valid;
    valid = (rw == RD_R) || (rw == WR_R);
    repeat (pre) @(negedge clk);
    bus.act_rdy    = (path != 0);
    bus.no_act_rdy = (path != 1);
    bus.act_rw     = rw;
    bus.col_addr   = col;
    @(negedge clk);
    bus.act_rdy    = 1'b0;
    bus.no_act_rdy = 1'b0;
    bus.act_rw     = $urandom_range(0, 7);
    bus.col_addr   = 10'($urandom);
    a = cyc;
    t_cas = -1; t_ds = -1; t_busy0 = -1; t_idle = -1;
    n_busy = 0; n_cas = 0; n_err = 0;
    idle_at_a = 1'bx; col_seen = '0; req_seen = '0;
    for (int k = 0; k < 100; k++) begin
      if (bus.cas_rdy) begin
        n_cas++;
        if (t_cas < 0) begin t_cas = cyc; col_seen = bus.cas_col; req_seen = bus.cas_req; end
      end
      if (bus.data_start && t_ds < 0) t_ds = cyc;
      if (bus.data_busy) begin n_busy++; if (t_busy0 < 0) t_busy0 = cyc; end
      if (bus.req_err) n_err++;
      if (k == 0) idle_at_a = bus.cas_idle;
      if (k > 0 && bus.cas_idle) begin t_idle = cyc; break; end
      @(negedge clk);
    end
    if (!valid) begin
      int idle_low;
      idle_low = 0;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        if (bus.cas_rdy) n_cas++;
        if (bus.req_err) n_err++;
        if (!bus.cas_idle) idle_low++;
      end
      chk($sformatf("%s err_pulses", tag), n_err, 1);
      chk($sformatf("%s err_no_cas", tag), n_cas, 0);
      chk($sformatf("%s err_idle_at_accept", tag), idle_at_a, 1);
      chk($sformatf("%s err_idle_low_cycles", tag), idle_low, 0);
    end else begin
      lat = (rw == WR_R) ? L_WR : L_RD;
      exp_cas = a + ((path != 0) ? T_RCD : 1);
      if (prev_cas + T_CCD > exp_cas) exp_cas = prev_cas + T_CCD;
      if (rw == RD_R && last_wr_m && prev_cas + L_WR + HALF + T_WTR > exp_cas)
        exp_cas = prev_cas + L_WR + HALF + T_WTR;
      chk($sformatf("%s idle_drop", tag), idle_at_a, 0);
      chk($sformatf("%s cas_delay", tag), t_cas - a, exp_cas - a);
      chk($sformatf("%s cas_pulses", tag), n_cas, 1);
      chk($sformatf("%s cas_col", tag), col_seen, col);
      chk($sformatf("%s cas_req", tag), req_seen, rw);
      chk($sformatf("%s data_start", tag), t_ds - exp_cas, lat);
      chk($sformatf("%s busy_first", tag), t_busy0 - exp_cas, lat);
      chk($sformatf("%s busy_len", tag), n_busy, HALF);
      chk($sformatf("%s idle_back", tag), t_idle - exp_cas, lat + HALF + 1);
      chk($sformatf("%s no_err", tag), n_err, 0);
      prev_cas  = exp_cas;
      last_wr_m = (rw == WR_R);
    end
  endtask

  initial begin
    int n_cas, n_ds, path, r, pre;
    logic [2:0] rw;
    bus.act_rdy = 1'b0; bus.no_act_rdy = 1'b0; bus.act_rw = 3'd0; bus.col_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst cas_rdy", bus.cas_rdy, 0);
    chk("rst data_start", bus.data_start, 0);
    chk("rst data_busy", bus.data_busy, 0);
    chk("rst req_err", bus.req_err, 0);
    chk("rst cas_idle", bus.cas_idle, 1);
    chk("rst cas_req", bus.cas_req, 0);
    chk("rst cas_col", bus.cas_col, 0);
    reset = 1'b0;
    model_reset();

    issue(0, 0, RD_R, 10'h055, "t1_rd_hit");
    issue(2, 1, WR_R, 10'h3FF, "t2_wr_act");
    issue(0, 0, WR_R, 10'h123, "t3_wr_hit");
    issue(0, 0, RD_R, 10'h0AA, "t3_rd_after_wr");
    issue(0, 0, RD_R, 10'h155, "t3_rd_after_rd");
    issue(1, 2, RD_R, 10'h200, "t4_both");
    issue(0, 0, 3'b111, 10'h011, "t5_bad_type");
    issue(0, 0, WR_R, 10'h001, "t5_after_err_wr");
    issue(0, 0, RD_R, 10'h002, "t5_after_err_rd");

    // Reset part-way through the tRCD wait abandons the request.
    @(negedge clk);
    bus.act_rdy = 1'b1; bus.act_rw = RD_R; bus.col_addr = 10'h0F0;
    @(negedge clk);
    bus.act_rdy = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    chk("t6 idle_after_reset", bus.cas_idle, 1);
    n_cas = 0; n_ds = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.cas_rdy) n_cas++;
      if (bus.data_start) n_ds++;
    end
    chk("t6 no_cas", n_cas, 0);
    chk("t6 no_data_start", n_ds, 0);

    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) rw = (($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(3, 7)));
      else if (r < 6) rw = RD_R;
      else rw = WR_R;
      path = $urandom_range(0, 2);
      pre  = (($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3));
      issue(pre, path, rw, 10'($urandom), $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
